// File: rtl/multi_frequency_analyzer.sv
// Classifies synchronised half-periods of sample_data into NUM_BINS programmable tick ranges per window.
// Optional feature macro MFA_HIT_COUNT_EN adds bin_hits, the per-bin count of matched intervals.
module multi_frequency_analyzer #(
   parameter int NUM_BINS     = 4,
   parameter int TICK_WIDTH   = 16,
   parameter int ACC_WIDTH    = 32,
   parameter int WINDOW_TICKS = 50000
) (
   input  logic                           clock,
   input  logic                           clear,
   input  logic                           enable,
   input  logic                           sample_data,
   input  logic [NUM_BINS*TICK_WIDTH-1:0] bin_low_ticks,
   input  logic [NUM_BINS*TICK_WIDTH-1:0] bin_high_ticks,
   output logic [NUM_BINS*ACC_WIDTH-1:0]  bin_acc,
   output logic [ACC_WIDTH-1:0]           unmatched_acc,
   output logic                           result_valid,
   output logic                           result_overflow,
`ifdef MFA_HIT_COUNT_EN
   output logic [NUM_BINS*TICK_WIDTH-1:0] bin_hits,
`endif
   output logic                           window_active
);
   localparam int WCW = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
   localparam int BW  = $clog2(NUM_BINS + 1);
   localparam int SW  = ((ACC_WIDTH > TICK_WIDTH) ? ACC_WIDTH : TICK_WIDTH) + 1;
   localparam logic [TICK_WIDTH-1:0] TICK_MAX = '1;
   localparam logic [TICK_WIDTH-1:0] TICK_ONE = TICK_WIDTH'(1);
   localparam logic [ACC_WIDTH-1:0]  ACC_MAX  = '1;
   localparam logic [WCW-1:0]        WIN_LAST = WCW'(WINDOW_TICKS - 1);
   localparam logic [WCW-1:0]        WIN_ONE  = WCW'(1);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE} state_t;

   state_t                       r_state;
   logic                         r_sync1, r_sync2, r_prev;
   logic [TICK_WIDTH-1:0]        r_cnt;
   logic [WCW-1:0]               r_win_cnt;
   logic                         r_win_id;
   logic                         r_window_active;
   logic [TICK_WIDTH-1:0]        r_low  [NUM_BINS];
   logic [TICK_WIDTH-1:0]        r_high [NUM_BINS];
   logic                         r_s1_vld, r_s1_win;
   logic [BW-1:0]                r_s1_bin;
   logic [TICK_WIDTH-1:0]        r_s1_len;
   // Two banks so the closing window can be read out while the next one accumulates.
   logic [ACC_WIDTH-1:0]         r_acc [2][NUM_BINS+1];
   logic [1:0]                   r_ovf;
   logic                         r_pub_d1, r_pub_d2, r_pub_bank_d1, r_pub_bank_d2;
   logic [NUM_BINS*ACC_WIDTH-1:0] r_bin_acc;
   logic [ACC_WIDTH-1:0]         r_unmatched_acc;
   logic                         r_result_valid, r_result_overflow;

   logic                         w_edge, w_sat, w_win_end, w_abort;
   logic [TICK_WIDTH-1:0]        w_len;
   logic [BW-1:0]                w_bin;
   logic [ACC_WIDTH:0]           w_add;

   function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                  input logic [TICK_WIDTH-1:0] b);
      logic [SW-1:0] s;
      s = SW'(a) + SW'(b);
      if (s > SW'(ACC_MAX)) sat_add = {1'b1, ACC_MAX};
      else                  sat_add = {1'b0, ACC_WIDTH'(s)};
   endfunction

   assign w_edge    = r_sync2 ^ r_prev;
   assign w_sat     = (r_cnt == TICK_MAX);
   assign w_len     = w_sat ? TICK_MAX : r_cnt + TICK_ONE;
   assign w_win_end = (r_state == S_MEASURE) && (r_win_cnt == WIN_LAST);
   assign w_abort   = !enable;
   assign w_add     = sat_add(r_acc[r_s1_win][r_s1_bin], r_s1_len);

   // Descending scan so the lowest matching bin index wins; index NUM_BINS means unmatched.
   always_comb begin
      w_bin = BW'(NUM_BINS);
      if (!w_sat) begin
         for (int i = NUM_BINS - 1; i >= 0; i--) begin
            if (w_len >= r_low[i] && w_len <= r_high[i]) w_bin = BW'(i);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= sample_data;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         if (w_edge)      r_cnt <= '0;
         else if (!w_sat) r_cnt <= r_cnt + TICK_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         r_state         <= S_IDLE;
         r_win_cnt       <= '0;
         r_win_id        <= 1'b0;
         r_window_active <= 1'b0;
         for (int i = 0; i < NUM_BINS; i++) begin
            r_low[i]  <= '0;
            r_high[i] <= '0;
         end
      end else if (w_abort) begin
         r_state         <= S_IDLE;
         r_win_cnt       <= '0;
         r_window_active <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_ARM;
               for (int i = 0; i < NUM_BINS; i++) begin
                  r_low[i]  <= bin_low_ticks[i*TICK_WIDTH +: TICK_WIDTH];
                  r_high[i] <= bin_high_ticks[i*TICK_WIDTH +: TICK_WIDTH];
               end
            end
            S_ARM: begin
               // The arming edge cycle is window cycle 0, so MEASURE starts at cycle 1.
               if (w_edge) begin
                  r_state         <= S_MEASURE;
                  r_win_cnt       <= WIN_ONE;
                  r_window_active <= 1'b1;
               end
            end
            S_MEASURE: begin
               if (w_win_end) begin
                  r_win_cnt <= '0;
                  r_win_id  <= ~r_win_id;
               end else begin
                  r_win_cnt <= r_win_cnt + WIN_ONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (clear || w_abort) begin
         r_s1_vld      <= 1'b0;
         r_s1_win      <= 1'b0;
         r_s1_bin      <= '0;
         r_s1_len      <= '0;
         r_pub_d1      <= 1'b0;
         r_pub_d2      <= 1'b0;
         r_pub_bank_d1 <= 1'b0;
         r_pub_bank_d2 <= 1'b0;
      end else begin
         r_s1_vld      <= w_edge && (r_state == S_MEASURE);
         r_s1_win      <= r_win_id;
         r_s1_bin      <= w_bin;
         r_s1_len      <= w_len;
         r_pub_d1      <= w_win_end;
         r_pub_bank_d1 <= r_win_id;
         r_pub_d2      <= r_pub_d1;
         r_pub_bank_d2 <= r_pub_bank_d1;
      end
   end

   always_ff @(posedge clock) begin
      if (clear || w_abort) begin
         r_ovf <= '0;
         for (int w = 0; w < 2; w++)
            for (int b = 0; b <= NUM_BINS; b++) r_acc[w][b] <= '0;
      end else begin
         if (r_s1_vld) begin
            r_acc[r_s1_win][r_s1_bin] <= w_add[ACC_WIDTH-1:0];
            if (w_add[ACC_WIDTH]) r_ovf[r_s1_win] <= 1'b1;
         end
         if (r_pub_d2) begin
            r_ovf[r_pub_bank_d2] <= 1'b0;
            for (int b = 0; b <= NUM_BINS; b++) r_acc[r_pub_bank_d2][b] <= '0;
         end
      end
   end

`ifdef MFA_HIT_COUNT_EN
   logic [TICK_WIDTH-1:0]         r_hits [2][NUM_BINS];
   logic [NUM_BINS*TICK_WIDTH-1:0] r_bin_hits;

   always_ff @(posedge clock) begin
      if (clear || w_abort) begin
         for (int w = 0; w < 2; w++)
            for (int b = 0; b < NUM_BINS; b++) r_hits[w][b] <= '0;
      end else begin
         for (int b = 0; b < NUM_BINS; b++) begin
            if (r_s1_vld && r_s1_bin == BW'(b) && r_hits[r_s1_win][b] != TICK_MAX)
               r_hits[r_s1_win][b] <= r_hits[r_s1_win][b] + TICK_ONE;
            if (r_pub_d2) r_hits[r_pub_bank_d2][b] <= '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         r_bin_hits <= '0;
      end else if (r_pub_d2 && !w_abort) begin
         for (int b = 0; b < NUM_BINS; b++)
            r_bin_hits[b*TICK_WIDTH +: TICK_WIDTH] <= r_hits[r_pub_bank_d2][b];
      end
   end

   assign bin_hits = r_bin_hits;
`endif

   always_ff @(posedge clock) begin
      if (clear) begin
         r_bin_acc         <= '0;
         r_unmatched_acc   <= '0;
         r_result_valid    <= 1'b0;
         r_result_overflow <= 1'b0;
      end else begin
         r_result_valid <= r_pub_d2 && !w_abort;
         if (r_pub_d2 && !w_abort) begin
            for (int b = 0; b < NUM_BINS; b++)
               r_bin_acc[b*ACC_WIDTH +: ACC_WIDTH] <= r_acc[r_pub_bank_d2][b];
            r_unmatched_acc   <= r_acc[r_pub_bank_d2][NUM_BINS];
            r_result_overflow <= r_ovf[r_pub_bank_d2];
         end
      end
   end

   assign bin_acc         = r_bin_acc;
   assign unmatched_acc   = r_unmatched_acc;
   assign result_valid    = r_result_valid;
   assign result_overflow = r_result_overflow;
   assign window_active   = r_window_active;

endmodule

// File: tb/tb_multi_frequency_analyzer.sv
// Randomised and directed bench: a timestamp-level model of windows and intervals scores two instances (24- and 8-bit accumulators).
`timescale 1ns/1ps
module tb_multi_frequency_analyzer;
   localparam int NB = 2, TW = 16, AW = 24, AWB = 8, W = 1000;
   localparam longint AMAX = (64'd1 << AW) - 1;
   localparam longint BMAX = (64'd1 << AWB) - 1;

   logic clock = 1'b0, clear = 1'b1, enable = 1'b0, sample_data = 1'b0;
   logic [NB*TW-1:0]  lo_bus = '0, hi_bus = '0;
   logic [NB*AW-1:0]  acc_a;
   logic [AW-1:0]     unm_a;
   logic              vld_a, ovf_a, act_a;
   logic [NB*AWB-1:0] acc_b;
   logic [AWB-1:0]    unm_b;
   logic              vld_b, ovf_b, act_b;
`ifdef MFA_HIT_COUNT_EN
   logic [NB*TW-1:0]  hits_a, hits_b;
`endif

   int     errors = 0, checks = 0;
   longint cyc = 0;
   int     lo[2], hi[2];
   typedef struct {longint cyc; longint a0; longint a1; longint u; logic ovf; longint h0; longint h1;} rec_t;
   rec_t   res_a[$], res_b[$];
   longint tog_q[$];

   multi_frequency_analyzer #(.NUM_BINS(NB), .TICK_WIDTH(TW), .ACC_WIDTH(AW), .WINDOW_TICKS(W)) u_dut_a (
      .clock(clock), .clear(clear), .enable(enable), .sample_data(sample_data),
      .bin_low_ticks(lo_bus), .bin_high_ticks(hi_bus),
      .bin_acc(acc_a), .unmatched_acc(unm_a), .result_valid(vld_a), .result_overflow(ovf_a),
`ifdef MFA_HIT_COUNT_EN
      .bin_hits(hits_a),
`endif
      .window_active(act_a));

   multi_frequency_analyzer #(.NUM_BINS(NB), .TICK_WIDTH(TW), .ACC_WIDTH(AWB), .WINDOW_TICKS(W)) u_dut_b (
      .clock(clock), .clear(clear), .enable(enable), .sample_data(sample_data),
      .bin_low_ticks(lo_bus), .bin_high_ticks(hi_bus),
      .bin_acc(acc_b), .unmatched_acc(unm_b), .result_valid(vld_b), .result_overflow(ovf_b),
`ifdef MFA_HIT_COUNT_EN
      .bin_hits(hits_b),
`endif
      .window_active(act_b));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin : mon
      rec_t r;
      if (vld_a) begin
         r.cyc = cyc; r.a0 = longint'(acc_a[0 +: AW]); r.a1 = longint'(acc_a[AW +: AW]);
         r.u = longint'(unm_a); r.ovf = ovf_a; r.h0 = 0; r.h1 = 0;
`ifdef MFA_HIT_COUNT_EN
         r.h0 = longint'(hits_a[0 +: TW]); r.h1 = longint'(hits_a[TW +: TW]);
`endif
         res_a.push_back(r);
      end
      if (vld_b) begin
         r.cyc = cyc; r.a0 = longint'(acc_b[0 +: AWB]); r.a1 = longint'(acc_b[AWB +: AWB]);
         r.u = longint'(unm_b); r.ovf = ovf_b; r.h0 = 0; r.h1 = 0;
         res_b.push_back(r);
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint sat(input longint v, input longint m);
      return (v > m) ? m : v;
   endfunction

   function automatic int pick(input int mode, input int h_fix);
      return (mode == 0) ? h_fix : int'($urandom_range(130, 30));
   endfunction

   task automatic set_bins(input int l0, input int h0, input int l1, input int h1);
      lo[0] = l0; hi[0] = h0; lo[1] = l1; hi[1] = h1;
      lo_bus = {TW'(l1), TW'(l0)};
      hi_bus = {TW'(h1), TW'(h0)};
   endtask

   task automatic check_zero(input string name);
      check_val({name, " acc_a"}, acc_a, 0);
      check_val({name, " unm_a"}, unm_a, 0);
      check_val({name, " vld_a"}, vld_a, 0);
      check_val({name, " ovf_a"}, ovf_a, 0);
      check_val({name, " act_a"}, act_a, 0);
      check_val({name, " acc_b"}, acc_b, 0);
      check_val({name, " ovf_b"}, ovf_b, 0);
`ifdef MFA_HIT_COUNT_EN
      check_val({name, " hits_a"}, hits_a, 0);
`endif
   endtask

   // Windows start at the arming toggle; each interval belongs to the window holding its closing toggle.
   task automatic check_windows(input string name, input longint d, input bit hold);
      int nexp;
      longint t0, len, s0, s1, su, n0, n1;
      nexp = 0; t0 = 0; s0 = 0; s1 = 0; su = 0; n0 = 0; n1 = 0;
      if (tog_q.size() > 0) begin
         t0 = tog_q[0];
         while (t0 + longint'(nexp + 1) * W + 4 <= d) nexp++;
      end
      check_val({name, " count_a"}, res_a.size(), nexp);
      check_val({name, " count_b"}, res_b.size(), nexp);
      for (int k = 0; k < nexp; k++) begin
         s0 = 0; s1 = 0; su = 0; n0 = 0; n1 = 0;
         for (int i = 1; i < tog_q.size(); i++) begin
            if ((tog_q[i] - t0) / W == k) begin
               len = tog_q[i] - tog_q[i-1];
               if (len >= lo[0] && len <= hi[0])      begin s0 += len; n0++; end
               else if (len >= lo[1] && len <= hi[1]) begin s1 += len; n1++; end
               else su += len;
            end
         end
         if (k < res_a.size()) begin
            check_val($sformatf("%s w%0d time", name, k), res_a[k].cyc, t0 + longint'(k + 1) * W + 4);
            check_val($sformatf("%s w%0d acc0", name, k), res_a[k].a0, sat(s0, AMAX));
            check_val($sformatf("%s w%0d acc1", name, k), res_a[k].a1, sat(s1, AMAX));
            check_val($sformatf("%s w%0d unm", name, k), res_a[k].u, sat(su, AMAX));
            check_val($sformatf("%s w%0d ovf", name, k), res_a[k].ovf, (s0 > AMAX) || (s1 > AMAX) || (su > AMAX));
`ifdef MFA_HIT_COUNT_EN
            check_val($sformatf("%s w%0d hits0", name, k), res_a[k].h0, n0);
            check_val($sformatf("%s w%0d hits1", name, k), res_a[k].h1, n1);
`endif
         end
         if (k < res_b.size()) begin
            check_val($sformatf("%s w%0d b_acc0", name, k), res_b[k].a0, sat(s0, BMAX));
            check_val($sformatf("%s w%0d b_acc1", name, k), res_b[k].a1, sat(s1, BMAX));
            check_val($sformatf("%s w%0d b_unm", name, k), res_b[k].u, sat(su, BMAX));
            check_val($sformatf("%s w%0d b_ovf", name, k), res_b[k].ovf, (s0 > BMAX) || (s1 > BMAX) || (su > BMAX));
         end
      end
      if (hold && nexp > 0) begin
         check_val({name, " hold acc0"}, acc_a[0 +: AW], sat(s0, AMAX));
         check_val({name, " hold acc1"}, acc_a[AW +: AW], sat(s1, AMAX));
         check_val({name, " hold unm"}, unm_a, sat(su, AMAX));
      end
   endtask

   task automatic run_scen(input string name, input int mode, input int h_fix, input int ncyc, input bit do_clear);
      int h, cnt, c;
      bit done;
      longint d;
      tog_q.delete(); res_a.delete(); res_b.delete();
      enable = 1'b1;
      h = pick(mode, h_fix); cnt = 0; c = 0; done = 1'b0;
      while (!done) begin
         @(posedge clock); #1;
         c++; cnt++;
         if (c == ncyc / 2) check_val({name, " active"}, act_a, 1);
         if (cnt >= h) begin
            sample_data = ~sample_data;
            tog_q.push_back(cyc);
            cnt = 0;
            h = pick(mode, h_fix);
         end
         if (c >= ncyc) begin
            if (!do_clear) done = 1'b1;
            else if (sample_data == 1'b0 && cnt == 10) done = 1'b1;
            else if (c > ncyc + 2000) begin
               check_val({name, " clear_wait"}, c, ncyc);
               done = 1'b1;
            end
         end
      end
      d = cyc;
      if (do_clear) begin
         clear = 1'b1;
         @(posedge clock); #1;
         clear = 1'b0;
         @(negedge clock);
         check_zero({name, " after_clear"});
      end else begin
         enable = 1'b0;
         cnt = 0;
         for (int i = 0; i < 1200; i++) begin
            @(posedge clock); #1;
            cnt++;
            if (cnt >= h && i < 1180) begin
               sample_data = ~sample_data;
               cnt = 0;
            end
         end
         check_val({name, " idle_active"}, act_a, 0);
      end
      check_windows(name, d, !do_clear);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      set_bins(45, 55, 90, 110);
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_zero("reset");
      @(posedge clock); #1;
      clear = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      run_scen("h50", 0, 50, 3700, 1'b0);
      run_scen("h100", 0, 100, 3700, 1'b0);
      run_scen("h70", 0, 70, 3700, 1'b0);
      run_scen("h54", 0, 54, 3300, 1'b0);
      run_scen("h56", 0, 56, 3300, 1'b0);
      run_scen("rnd", 1, 0, 3600 + int'($urandom_range(500, 0)), 1'b0);
      run_scen("clr", 0, 50, 2600, 1'b1);
      run_scen("post_clr", 0, 100, 3300, 1'b0);
      set_bins(40, 60, 40, 60);
      run_scen("overlap", 0, 50, 3300, 1'b0);
      set_bins(45, 55, 90, 110);
      run_scen("rnd2", 1, 0, 3200 + int'($urandom_range(500, 0)), 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
